// File: rtl/mul32_shift_add.sv
// Sequential 32x32 -> 64-bit unsigned shift-and-add multiplier built around one Kogge-Stone adder.
// Latency: 32 cycles from operand accept to outValid; one result per 34 cycles with outReady held high.
// Backpressure: inReady only in IDLE; the result is held in DONE until outReady.

// Combinational 32-bit Kogge-Stone adder: parallel-prefix carry tree, five doubling levels.
module kogge_stone_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cIn,
  output logic [31:0] s,
  output logic        cOut
);

  // Generate/propagate for each prefix level; level 0 is the per-bit pair.
  logic [31:0] w_g [0:5];
  logic [31:0] w_p [0:5];
  logic [32:0] w_c;

  // Prefix tree: at distance d each bit merges with the group d bits below it.
  always_comb begin
    w_g[0] = a & b;
    w_p[0] = a ^ b;
    // Fold the carry-in into bit 0 so every prefix group already includes it.
    w_g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cIn);
    for (int l = 0; l < 5; l++) begin
      // Bits below d have no partner: shifted-in zeros leave G unchanged,
      // and shifted-in ones leave P unchanged.
      w_g[l+1] = w_g[l] | (w_p[l] & (w_g[l] << (1 << l)));
      w_p[l+1] = w_p[l] & ((w_p[l] << (1 << l)) | ~(32'hFFFF_FFFF << (1 << l)));
    end
    w_c  = {w_g[5], cIn};
    s    = w_p[0] ^ w_c[31:0];
    cOut = w_c[32];
  end

endmodule

// Operand/control stage: drives the adder from registered state and accumulates the product.
module mul32_shift_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        outValid,
  input  logic        outReady,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mcand;
  logic [4:0]  r_count;

  logic        w_load;
  logic        w_step;
  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;

  // The multiplier LSB selects whether this step adds the multiplicand.
  assign w_addend = r_lo[0] ? r_mcand : 32'd0;

  kogge_stone_adder32 u_adder (
    .a    (r_hi),
    .b    (w_addend),
    .cIn  (1'b0),
    .s    (w_sum),
    .cOut (w_cout)
  );

  // Product is always the register pair; it only means something while outValid is high.
  assign product = {r_hi, r_lo};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake outputs and datapath enables.
  always_comb begin
    w_state_nxt = r_state;
    inReady     = 1'b0;
    outValid    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        // The 32nd step retires here; count wraps to 0 on the same edge.
        if (r_count == 5'd31) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, then shift {cOut, sum, lo} right by one per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_mcand <= 32'd0;
      r_count <= 5'd0;
    end else if (w_load) begin
      r_hi    <= 32'd0;
      r_lo    <= b;
      r_mcand <= a;
      r_count <= 5'd0;
    end else if (w_step) begin
      // The adder carry becomes the new MSB, so a 33-bit partial sum is never truncated.
      r_hi    <= {w_cout, w_sum[31:1]};
      r_lo    <= {w_sum[0], r_lo[31:1]};
      r_count <= r_count + 5'd1;
    end
  end

endmodule

// File: tb/tb_mul32_shift_add.sv
// Directed and randomized bench for mul32_shift_add against a plain 64-bit multiply model.
// Inputs change on the falling edge or 1 time unit after the rising edge; outputs are sampled 1 unit after the rising edge.
// Expected products are queued at accept and retired at each output handshake.
module tb_mul32_shift_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] a;
  logic [31:0] b;
  logic        outValid;
  logic        outReady;
  logic [63:0] product;

  int          errors = 0;
  int          checks = 0;
  int          n_in   = 0;
  int          n_out  = 0;
  logic [63:0] exp_q[$];

  mul32_shift_add dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .a        (a),
    .b        (b),
    .outValid (outValid),
    .outReady (outReady),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for the accept edge, then scramble the inputs.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_op);
    int n;
    @(negedge clk);
    a = ta;
    b = tb_op;
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 200), 64'd1);
    exp_q.push_back({32'd0, ta} * {32'd0, tb_op});
    n_in++;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Count rising edges from accept until outValid; optionally check inReady stays low while busy.
  task automatic wait_done(input bit check_busy);
    int lat;
    lat = 0;
    while (!outValid && lat < 100) begin
      if (check_busy) chk("inReady_busy", 64'(inReady), 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd32);
  endtask

  // Compare the result, hold it for 'hold' cycles, then complete the output handshake.
  task automatic finish_op(input int hold, input bit pulse);
    logic [63:0] held;
    logic [63:0] expected;
    held = product;
    if (exp_q.size() == 0) begin
      chk("unexpected_output", 64'd1, 64'd0);
      expected = 64'd0;
    end else begin
      expected = exp_q.pop_front();
    end
    chk("product", product, expected);
    for (int i = 0; i < hold; i++) begin
      outReady = 1'b0;
      if (pulse) begin
        inValid = i[0];
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(outValid), 64'd1);
      chk("hold_product", product, held);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    n_out++;
    chk("inReady_after_out", 64'(inReady), 64'd1);
    chk("outValid_after_out", 64'(outValid), 64'd0);
  endtask

  task automatic full_op(input logic [31:0] ta, input logic [31:0] tb_op, input int hold, input bit pulse);
    start_op(ta, tb_op);
    wait_done(1'b1);
    finish_op(hold, pulse);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_inReady", 64'(inReady), 64'd1);
    chk("reset_outValid", 64'(outValid), 64'd0);
    chk("reset_product", product, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_inReady", 64'(inReady), 64'd1);

    // Basic products and carry-heavy / zero boundaries.
    full_op(32'd3, 32'd5, 0, 1'b0);
    full_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    full_op(32'h8000_0000, 32'd2, 0, 1'b0);
    full_op(32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    full_op(32'hDEAD_BEEF, 32'd0, 0, 1'b0);
    full_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);

    // Hold the result under backpressure while inValid pulses.
    full_op(32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b1);

    // Reset during RUN step 17 discards the partial result.
    start_op(32'd1234, 32'd5678);
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    chk("midrun_outValid_pre", 64'(outValid), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrun_rst_outValid", 64'(outValid), 64'd0);
    chk("midrun_rst_inReady", 64'(inReady), 64'd1);
    chk("midrun_rst_product", product, 64'd0);
    exp_q.delete();
    n_in--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    full_op(32'd7, 32'd6, 0, 1'b0);

    // Reset while DONE also clears outputs at once.
    start_op(32'd11, 32'd13);
    wait_done(1'b0);
    rst = 1'b1;
    #1;
    chk("done_rst_outValid", 64'(outValid), 64'd0);
    chk("done_rst_product", product, 64'd0);
    exp_q.delete();
    n_in--;
    @(negedge clk);
    rst = 1'b0;

    // Random operands with random output backpressure.
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      start_op(ra, rb);
      wait_done(1'b0);
      finish_op(int'($urandom_range(0, 3)), 1'b0);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("in_out_count", 64'(n_out), 64'(n_in));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
